// File: rtl/mont_pkg.sv
// Shared types and constants for the parametrised Montgomery multiplier.
package mont_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOOP = 2'd1,
      ST_SUB  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Extra bits of the step adder above N: c + b + m < 4m needs N+2 bits.
   localparam int STEP_XW = 2;

endpackage

// File: rtl/montgomery_mul_param_if.sv
// Request/response bundle between the RSA exponentiation controller and the multiplier.
interface montgomery_mul_param_if #(
   parameter int N = 512
);
   logic         start;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic [N-1:0] in_m;
   logic [N-1:0] result;
   logic         done;
   logic         busy;
   logic         err;

   modport master (
      output start, in_a, in_b, in_m,
      input  result, done, busy, err
   );

   modport slave (
      input  start, in_a, in_b, in_m,
      output result, done, busy, err
   );
endinterface

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: c_next = (c + a_i*b + q*m) / 2 with q chosen to make the sum even.
module mont_step
   import mont_pkg::*;
#(
   parameter int N = 512
) (
   input  logic [N:0]   c,
   input  logic [N-1:0] b,
   input  logic [N-1:0] m,
   input  logic         a_i,
   output logic [N:0]   c_next
);

   localparam int SW = N + STEP_XW;

   logic [SW-1:0] t;
   logic [SW-1:0] u;

   always_comb begin
      t      = {1'b0, c} + (a_i ? {2'b00, b} : {SW{1'b0}});
      u      = t + (t[0] ? {2'b00, m} : {SW{1'b0}});
      // u is always even here, so dropping the low bit is an exact divide.
      c_next = (N+1)'(u >> 1);
   end

endmodule

// File: rtl/montgomery_mul_param.sv
// Radix-2 Montgomery multiplier: result = a*b*2^-N mod m in N+2 cycles, err on even m.
// Define MONT_CYCLE_CNT_EN to add the cycles port reporting the last operation length.
//
// state | meaning
// IDLE  | waiting for start; result/err held
// LOOP  | one radix-2 step per cycle, N cycles
// SUB   | final conditional subtraction of m
// DONE  | one-cycle done pulse, result/err valid
module montgomery_mul_param
   import mont_pkg::*;
#(
   parameter int N     = 512,
   parameter int CNT_W = $clog2(N+3)
) (
   input  logic             clk,
   input  logic             resetn,
`ifdef MONT_CYCLE_CNT_EN
   output logic [CNT_W-1:0] cycles,
`endif
   montgomery_mul_param_if.slave bus
);

   state_e           state_q, state_d;
   logic [N-1:0]     a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic [N-1:0]     m_q, m_d;
   logic [N-1:0]     result_q, result_d;
   logic [N:0]       c_q, c_d, c_step;
   logic [CNT_W-1:0] i_q, i_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic [N+1:0]     diff;
   logic [N+1:0]     sub_sel;
`ifdef MONT_CYCLE_CNT_EN
   logic [CNT_W-1:0] cyc_q, cyc_d;
`endif

   mont_step #(.N(N)) u_step (
      .c      (c_q),
      .b      (b_q),
      .m      (m_q),
      .a_i    (a_q[0]),
      .c_next (c_step)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      m_d      = m_q;
      c_d      = c_q;
      i_d      = i_q;
      result_d = result_q;
      err_d    = err_q;
`ifdef MONT_CYCLE_CNT_EN
      cyc_d    = cyc_q;
`endif
      diff     = {1'b0, c_q} - {2'b00, m_q};
      sub_sel  = diff[N+1] ? {1'b0, c_q} : diff;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_d = bus.in_a;
               b_d = bus.in_b;
               m_d = bus.in_m;
               c_d = '0;
               i_d = '0;
`ifdef MONT_CYCLE_CNT_EN
               cyc_d = CNT_W'(1);
`endif
               if (!bus.in_m[0]) begin
                  err_d    = 1'b1;
                  result_d = '0;
                  state_d  = ST_DONE;
               end else begin
                  state_d  = ST_LOOP;
               end
            end
         end
         ST_LOOP: begin
            // a is consumed LSB first by shifting, so the step always sees bit 0.
            c_d = c_step;
            a_d = a_q >> 1;
            i_d = i_q + CNT_W'(1);
`ifdef MONT_CYCLE_CNT_EN
            cyc_d = cyc_q + CNT_W'(1);
`endif
            if (i_q == CNT_W'(N-1)) state_d = ST_SUB;
         end
         ST_SUB: begin
            result_d = N'(sub_sel);
            err_d    = 1'b0;
`ifdef MONT_CYCLE_CNT_EN
            cyc_d = cyc_q + CNT_W'(1);
`endif
            state_d  = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      done_d = (state_d == ST_DONE);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         c_q      <= '0;
         i_q      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
`ifdef MONT_CYCLE_CNT_EN
         cyc_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         m_q      <= m_d;
         c_q      <= c_d;
         i_q      <= i_d;
         result_q <= result_d;
         err_q    <= err_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
`ifdef MONT_CYCLE_CNT_EN
         cyc_q    <= cyc_d;
`endif
      end
   end

   assign bus.result = result_q;
   assign bus.err    = err_q;
   assign bus.done   = done_q;
   assign bus.busy   = busy_q;
`ifdef MONT_CYCLE_CNT_EN
   assign cycles     = cyc_q;
`endif

endmodule

// File: tb/tb_montgomery_mul_param.sv
// Scoreboard bench for montgomery_mul_param: directed N=8 vectors plus N=512 random odd moduli.
module tb_montgomery_mul_param;

   typedef struct {
      logic [511:0] res;
      logic         err;
      int           acc;
      int           lat;
      int           cyc;
   } exp_t;

   logic clk = 1'b0;
   logic resetn;
   int   cyc_cnt = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   done8 = 0;
   int   done512 = 0;
   exp_t q8[$];
   exp_t q512[$];

   montgomery_mul_param_if #(.N(8))   bus8 ();
   montgomery_mul_param_if #(.N(512)) bus512 ();

`ifdef MONT_CYCLE_CNT_EN
   logic [3:0] cycles8;
   logic [9:0] cycles512;
`endif

   montgomery_mul_param #(.N(8)) u_dut8 (
      .clk    (clk),
      .resetn (resetn),
`ifdef MONT_CYCLE_CNT_EN
      .cycles (cycles8),
`endif
      .bus    (bus8)
   );

   montgomery_mul_param #(.N(512)) u_dut512 (
      .clk    (clk),
      .resetn (resetn),
`ifdef MONT_CYCLE_CNT_EN
      .cycles (cycles512),
`endif
      .bus    (bus512)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic void chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // Reference: plain product reduced mod m, then halved mod m 512 times.
   function automatic logic [511:0] mont512(input logic [511:0] a, input logic [511:0] b,
                                            input logic [511:0] m);
      logic [1023:0] x;
      x = ({512'd0, a} * {512'd0, b}) % {512'd0, m};
      for (int k = 0; k < 512; k++) begin
         if (x[0]) x = x + {512'd0, m};
         x = x >> 1;
      end
      return x[511:0];
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (resetn && bus8.done) begin
         done8++;
         if (q8.size() == 0) chk("unexpected_done8", 1, 0);
         else begin
            e = q8.pop_front();
            chk("result8", {504'd0, bus8.result}, e.res);
            chk("err8", bus8.err, e.err);
            chk("latency8", cyc_cnt - e.acc, e.lat);
`ifdef MONT_CYCLE_CNT_EN
            chk("cycles8", cycles8, e.cyc);
`endif
         end
      end
      if (resetn && bus512.done) begin
         done512++;
         if (q512.size() == 0) chk("unexpected_done512", 1, 0);
         else begin
            e = q512.pop_front();
            chk("result512", bus512.result, e.res);
            chk("err512", bus512.err, e.err);
            chk("latency512", cyc_cnt - e.acc, e.lat);
`ifdef MONT_CYCLE_CNT_EN
            chk("cycles512", cycles512, e.cyc);
`endif
         end
      end
   end

   task automatic wait_idle8();
      int k = 0;
      while (bus8.busy && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (bus8.busy) chk("idle8_timeout", 1, 0);
   endtask

   task automatic wait_idle512();
      int k = 0;
      while (bus512.busy && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (bus512.busy) chk("idle512_timeout", 1, 0);
   endtask

   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                         input logic [7:0] r, input logic e);
      exp_t x;
      wait_idle8();
      bus8.in_a  = a;
      bus8.in_b  = b;
      bus8.in_m  = m;
      bus8.start = 1'b1;
      x.res = {504'd0, r};
      x.err = e;
      x.acc = cyc_cnt + 1;
      x.lat = e ? 0 : 9;
      x.cyc = e ? 1 : 10;
      q8.push_back(x);
      @(negedge clk);
      bus8.start = 1'b0;
   endtask

   task automatic issue512(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m,
                           input logic [511:0] r);
      exp_t x;
      wait_idle512();
      bus512.in_a  = a;
      bus512.in_b  = b;
      bus512.in_m  = m;
      bus512.start = 1'b1;
      x.res = r;
      x.err = 1'b0;
      x.acc = cyc_cnt + 1;
      x.lat = 513;
      x.cyc = 514;
      q512.push_back(x);
      @(negedge clk);
      bus512.start = 1'b0;
   endtask

   task automatic check_zero8(input string tag);
      chk({tag, "_result8"}, {504'd0, bus8.result}, 512'd0);
      chk({tag, "_done8"}, bus8.done, 0);
      chk({tag, "_busy8"}, bus8.busy, 0);
      chk({tag, "_err8"}, bus8.err, 0);
`ifdef MONT_CYCLE_CNT_EN
      chk({tag, "_cycles8"}, cycles8, 0);
`endif
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      exp_t x;
      int   d0, gap, k, acc;
      logic [511:0] ra, rb, rm;

      resetn = 1'b0;
      bus8.start = 1'b0;  bus8.in_a = '0;  bus8.in_b = '0;  bus8.in_m = '0;
      bus512.start = 1'b0; bus512.in_a = '0; bus512.in_b = '0; bus512.in_m = '0;
      repeat (3) @(negedge clk);
      check_zero8("reset");
      chk("reset_result512", bus512.result, 512'd0);
      chk("reset_busy512", bus512.busy, 0);
      chk("reset_done512", bus512.done, 0);
      chk("reset_err512", bus512.err, 0);
      resetn = 1'b1;
      @(negedge clk);

      // 5*7*256^-1 mod 13 = 1; 254*254 mod 255 = 1; even modulus; err clears on next op
      issue8(8'd5,   8'd7,   8'd13,  8'd1, 1'b0);
      issue8(8'd254, 8'd254, 8'd255, 8'd1, 1'b0);
      issue8(8'd5,   8'd7,   8'd12,  8'd0, 1'b1);
      issue8(8'd12,  8'd12,  8'd13,  8'd3, 1'b0);
      issue8(8'd1,   8'd1,   8'd13,  8'd3, 1'b0);
      issue8(8'd0,   8'd7,   8'd13,  8'd0, 1'b0);

      // start during LOOP is ignored; busy stays high throughout
      wait_idle8();
      d0 = done8;
      gap = 0;
      issue8(8'd5, 8'd7, 8'd13, 8'd1, 1'b0);
      k = 1;
      while (!bus8.done && k < 40) begin
         if (!bus8.busy) gap++;
         if (k == 3) begin
            bus8.start = 1'b1;
            bus8.in_a  = 8'd3;
         end else bus8.start = 1'b0;
         @(negedge clk);
         k++;
      end
      bus8.start = 1'b0;
      chk("busy_gap", gap, 0);
      repeat (20) @(negedge clk);
      chk("single_done", done8 - d0, 1);

      // start held high restarts every N+3 cycles
      wait_idle8();
      bus8.in_a = 8'd5; bus8.in_b = 8'd7; bus8.in_m = 8'd13;
      bus8.start = 1'b1;
      acc = cyc_cnt + 1;
      x.res = 512'd1; x.err = 1'b0; x.lat = 9; x.cyc = 10;
      x.acc = acc;      q8.push_back(x);
      x.acc = acc + 11; q8.push_back(x);
      repeat (12) @(negedge clk);
      bus8.start = 1'b0;

      // reset in LOOP cycle 4 aborts without done
      wait_idle8();
      d0 = done8;
      issue8(8'd5, 8'd7, 8'd13, 8'd1, 1'b0);
      repeat (3) @(negedge clk);
      resetn = 1'b0;
      #1;
      check_zero8("abort");
      q8.delete();
      q512.delete();
      repeat (20) @(negedge clk);
      chk("abort_no_done", done8 - d0, 0);
      resetn = 1'b1;
      @(negedge clk);
      issue8(8'd0, 8'd7, 8'd13, 8'd0, 1'b0);

      for (int n = 0; n < 100; n++) begin
         rm = rnd512() | 512'd1;
         rm[511] = (n % 2 == 0);
         ra = rnd512() % rm;
         rb = rnd512() % rm;
         issue512(ra, rb, rm, mont512(ra, rb, rm));
      end

      wait_idle8();
      wait_idle512();
      repeat (5) @(negedge clk);
      chk("q8_empty", q8.size(), 0);
      chk("q512_empty", q512.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
